// File: rtl/dmem_pkg.sv
// Shared types and the load lane-extract helper for the data memory unit.
package dmem_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned LANES  = 4;

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10,
      SIZE_X = 2'b11
   } size_e;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Select the addressed lane(s) of a little-endian word and extend to 32 bits.
   function automatic logic [DATA_W-1:0] load_extract(
      input logic [DATA_W-1:0] word,
      input logic [1:0]        off,
      input size_e             size,
      input logic              uns
   );
      logic [7:0]        b;
      logic [15:0]       h;
      logic [DATA_W-1:0] r;
      b = word[{off, 3'b000} +: 8];
      h = word[{off[1], 4'b0000} +: 16];
      case (size)
         SIZE_B:  r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
         SIZE_H:  r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the datapath and the data memory unit.
interface dmem_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              rsp_fault;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault
   );
endinterface

// File: rtl/dmem_ram.sv
// DEPTH x 32 single-port array with byte write enables and a registered read.
module dmem_ram #(
   parameter int unsigned DEPTH = 1024
) (
   input  logic                     clk,
   input  logic [3:0]               we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [31:0]              wdata,
   output logic [31:0]              rdata
);
   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // Byte-lane writes; read returns the word as it was before this edge.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata_q <= mem_q[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/dmem_unit.sv
// Data memory unit: init sweep FSM, request decode/fault checks and one-cycle response.
module dmem_unit
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned ADDR_W    = 32,
   parameter bit          INIT_ZERO = 1'b1
) (
   input  logic     clk,
   input  logic     rst,
   dmem_if.slave    bus,
   output logic     init_done
);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   init_ptr_q, init_ptr_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic               rsp_fault_q, rsp_fault_d;
   logic               rsp_load_q, rsp_load_d;
   logic [1:0]         off_q, off_d;
   size_e              size_q, size_d;
   logic               uns_q, uns_d;

   logic               accept_c;
   logic               fault_c;
   size_e              size_c;
   logic [1:0]         off_c;
   logic [IDX_W-1:0]   idx_c;
   logic [3:0]         be_c;
   logic [31:0]        lane_wdata_c;
   logic [3:0]         ram_we;
   logic [IDX_W-1:0]   ram_addr;
   logic [31:0]        ram_wdata;
   logic [31:0]        ram_rdata;

   assign accept_c = bus.req_valid && (state_q == ST_RUN);
   assign size_c   = size_e'(bus.req_size);
   assign off_c    = bus.req_addr[1:0];
   assign idx_c    = bus.req_addr[IDX_W+1:2];

   // Decode fault conditions and the little-endian store lanes.
   always_comb begin
      fault_c      = 1'b0;
      be_c         = 4'b0000;
      lane_wdata_c = bus.req_wdata;
      if ((bus.req_addr >> (IDX_W + 2)) != '0) fault_c = 1'b1;
      case (size_c)
         SIZE_B: begin
            be_c         = 4'b0001 << off_c;
            lane_wdata_c = {4{bus.req_wdata[7:0]}};
         end
         SIZE_H: begin
            if (off_c[0]) fault_c = 1'b1;
            be_c         = 4'b0011 << off_c;
            lane_wdata_c = {2{bus.req_wdata[15:0]}};
         end
         SIZE_W: begin
            if (off_c != 2'b00) fault_c = 1'b1;
            be_c = 4'b1111;
         end
         default: fault_c = 1'b1;
      endcase
   end

   // Next state, init sweep, array port mux and response capture.
   always_comb begin
      state_d     = state_q;
      init_ptr_d  = init_ptr_q;
      ram_we      = 4'b0000;
      ram_addr    = idx_c;
      ram_wdata   = lane_wdata_c;
      rsp_valid_d = accept_c;
      rsp_fault_d = accept_c && fault_c;
      rsp_load_d  = accept_c && !fault_c && !bus.req_we;
      off_d       = off_c;
      size_d      = size_c;
      uns_d       = bus.req_unsigned;
      case (state_q)
         ST_INIT: begin
            if (INIT_ZERO) begin
               ram_we     = 4'b1111;
               ram_addr   = init_ptr_q;
               ram_wdata  = '0;
               init_ptr_d = init_ptr_q + IDX_W'(1);
               if (init_ptr_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (accept_c && bus.req_we && !fault_c) ram_we = be_c;
         end
         default: state_d = ST_INIT;
      endcase
   end

   // State, init pointer and response registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_INIT;
         init_ptr_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_fault_q <= 1'b0;
         rsp_load_q  <= 1'b0;
         off_q       <= 2'b00;
         size_q      <= SIZE_B;
         uns_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_ptr_q  <= init_ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_fault_q <= rsp_fault_d;
         rsp_load_q  <= rsp_load_d;
         off_q       <= off_d;
         size_q      <= size_d;
         uns_q       <= uns_d;
      end
   end

   dmem_ram #(.DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   assign bus.req_ready = (state_q == ST_RUN);
   assign init_done     = (state_q == ST_RUN);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_fault = rsp_fault_q;
   assign bus.rsp_rdata = rsp_load_q ? load_extract(ram_rdata, off_q, size_q, uns_q) : 32'h0;

endmodule

// File: tb/tb_dmem_unit.sv
// Directed plus randomized bench for dmem_unit against a byte-array reference model.
module tb_dmem_unit;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned NBYTES = 4 * DEPTH;

   logic clk;
   logic rst;
   logic init_done;
   int   checks;
   int   failures;

   logic [7:0]  mem_m [NBYTES];
   logic [31:0] last_rdata;

   dmem_if #(.ADDR_W(ADDR_W)) bus ();

   dmem_unit #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_ZERO(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .init_done (init_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NBYTES; i++) mem_m[i] = 8'h00;
   endtask

   // Reference behaviour: little-endian byte array, faults from the address rules.
   task automatic model_op(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] er, output logic ef);
      int unsigned n;
      logic [31:0] val;
      logic [31:0] mask;
      er = 32'h0;
      ef = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
           (size == 2'd2 && addr % 4 != 0) || (addr >= NBYTES);
      if (!ef) begin
         n = 1 << size;
         if (we) begin
            for (int i = 0; i < int'(n); i++) mem_m[addr + i] = wdata[8*i +: 8];
         end else begin
            val = 32'h0;
            for (int i = 0; i < int'(n); i++) val = val | (32'(mem_m[addr + i]) << (8 * i));
            if (n < 4 && !uns) begin
               mask = (32'd1 << (8 * n)) - 32'd1;
               if (val[8*n-1]) val = val | ~mask;
            end
            er = val;
         end
      end
   endtask

   // One accepted request; response checked #1 after the accepting edge.
   task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] er;
      logic        ef;
      bus.req_valid    = 1'b1;
      bus.req_we       = we;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_addr     = addr;
      bus.req_wdata    = wdata;
      model_op(we, size, uns, addr, wdata, er, ef);
      @(posedge clk);
      #1;
      last_rdata = bus.rsp_rdata;
      check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_fault"}, 32'(bus.rsp_fault), 32'(ef));
      check({tag, "_rdata"}, bus.rsp_rdata, er);
   endtask

   task automatic idle(input string tag);
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_rdata"}, bus.rsp_rdata, 32'd0);
   endtask

   // Counts edges after release until ready; no response may appear meanwhile.
   task automatic wait_init(input string tag);
      int cnt;
      cnt = 0;
      while (cnt < 200) begin
         @(posedge clk);
         cnt++;
         #1;
         if (bus.req_ready) break;
         check({tag, "_busy_rsp"}, 32'(bus.rsp_valid), 32'd0);
      end
      bus.req_valid = 1'b0;
      check({tag, "_cycles"}, 32'(cnt), 32'(DEPTH));
      check({tag, "_done"}, 32'(init_done), 32'd1);
   endtask

   initial begin
      logic [31:0] a;
      logic [1:0]  sz;
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      bus.req_valid    = 1'b1;
      bus.req_we       = 1'b1;
      bus.req_size     = 2'd2;
      bus.req_unsigned = 1'b0;
      bus.req_addr     = 32'h20;
      bus.req_wdata    = 32'hFFFF_FFFF;
      model_clear();

      #1;
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rdata", bus.rsp_rdata, 32'd0);
      check("rst_fault", 32'(bus.rsp_fault), 32'd0);
      check("rst_done", 32'(init_done), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      wait_init("init");

      do_req("lw3c", 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0);
      check("tp_lw3c", last_rdata, 32'h0);
      do_req("lw20_ignored", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
      idle("idle0");

      do_req("sw08", 1'b1, 2'd2, 1'b0, 32'h08, 32'hDEADBEEF);
      do_req("lw08", 1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
      check("tp_lw08", last_rdata, 32'hDEADBEEF);

      do_req("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344);
      do_req("sb11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h000000A5);
      do_req("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
      check("tp_lw10", last_rdata, 32'h1122A544);
      do_req("lb11", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0);
      check("tp_lb11", last_rdata, 32'hFFFFFFA5);
      do_req("lbu11", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0);
      check("tp_lbu11", last_rdata, 32'h000000A5);
      do_req("lh12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0);
      check("tp_lh12", last_rdata, 32'h00001122);

      do_req("lh01", 1'b0, 2'd1, 1'b0, 32'h01, 32'h0);
      check("tp_lh01_fault", 32'(bus.rsp_fault), 32'd1);
      do_req("sw04", 1'b1, 2'd2, 1'b0, 32'h04, 32'hCAFEF00D);
      do_req("sw06", 1'b1, 2'd2, 1'b0, 32'h06, 32'h12345678);
      check("tp_sw06_fault", 32'(bus.rsp_fault), 32'd1);
      do_req("lw04", 1'b0, 2'd2, 1'b0, 32'h04, 32'h0);
      check("tp_lw04", last_rdata, 32'hCAFEF00D);
      do_req("size11", 1'b0, 2'd3, 1'b0, 32'h00, 32'h0);
      check("tp_size11_fault", 32'(bus.rsp_fault), 32'd1);
      do_req("addr40", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
      check("tp_addr40_fault", 32'(bus.rsp_fault), 32'd1);
      do_req("sw_hi", 1'b1, 2'd2, 1'b0, 32'h8000_0000, 32'h55555555);
      do_req("lw00", 1'b0, 2'd2, 1'b0, 32'h00, 32'h0);
      idle("idle1");

      for (int i = 0; i < 8; i++) do_req("b2b_sw", 1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom);
      for (int i = 0; i < 8; i++) do_req("b2b_lw", 1'b0, 2'd2, 1'b0, 32'(4 * i), 32'h0);
      idle("idle2");

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            idle("rnd_idle");
         end else begin
            sz = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) sz = 2'd3;
            a = 32'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            if ($urandom_range(0, 19) == 0) a = a | (32'd1 << $urandom_range(6, 31));
            do_req("rnd", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
         end
      end

      do_req("mid_lw", 1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
      check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
      check("mid_rst_done", 32'(init_done), 32'd0);
      bus.req_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("mid_rst_late", 32'(bus.rsp_valid), 32'd0);
      rst = 1'b0;
      wait_init("reinit");
      model_clear();
      do_req("post_lw08", 1'b0, 2'd2, 1'b0, 32'h08, 32'h0);
      do_req("post_lw3c", 1'b0, 2'd2, 1'b0, 32'h3C, 32'h0);
      idle("idle3");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/dmem_unit.md
# dmem_unit

Parametrised single-port data memory for the MIPS datapath. Serves byte, halfword and word loads and stores with sign/zero extension and little-endian byte lanes. Zero-initialises its array after reset and flags misaligned, out-of-range and illegal-size accesses. Sits between the ALU address output and the writeback mux, with a valid/ready request side and a one-cycle, non-backpressured response.

## Interface
- DEPTH, 1024, number of 32-bit words; power of two, ≥ 4
- ADDR_W, 32, width of the byte address
- INIT_ZERO, 1, 1 = zero every word after reset; 0 = skip the init sweep

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; low during init
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- rsp_valid  out  1  one-cycle pulse, one per accepted request
- rsp_rdata  out  32  extended load data; 0 for stores, faults and when rsp_valid=0
- rsp_fault  out  1  accepted request was rejected; qualified by rsp_valid
- init_done  out  1  high once the init sweep completes; stays high until rst

## Operation
- States: INIT, RUN.
  - Reset enters INIT with init_ptr=0.
  - INIT_ZERO=1: INIT writes 0 to word init_ptr each cycle and increments. After writing word DEPTH-1 it moves to RUN.
  - INIT_ZERO=0: INIT lasts one cycle, then moves to RUN.
- req_ready = (state==RUN). A request is accepted when req_valid && req_ready. Throughput is one per cycle.
- Decode: word index = req_addr[log2(DEPTH)+1:2]; offset = req_addr[1:0].
- Fault conditions (any one faults the request):
  - req_size==11
  - half with offset[0]=1
  - word with offset≠0
  - any req_addr bit above log2(DEPTH)+1 set
- A faulted request never modifies the array. It responds rsp_fault=1, rsp_rdata=0.
- Store, little-endian:
  - byte: lane = offset, writes wdata[7:0]
  - half: lanes offset and offset+1, writes wdata[15:0]
  - word: all four lanes
  - Other lanes are unchanged. Response: rsp_fault=0, rsp_rdata=0.
- Load: reads the whole word, selects the lane(s) by offset, then sign- or zero-extends to 32 bits per req_unsigned. req_unsigned is ignored for word loads.
- Store followed by load to the same word on the next cycle returns the updated word. Only one request is accepted per cycle, so no forwarding path is needed.

## Timing
- Reset values: req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_fault 0, init_done 0, state INIT, init_ptr 0.
- Init duration:
  - INIT_ZERO=1: req_ready and init_done rise exactly DEPTH cycles after the first clock edge following rst deassertion.
  - INIT_ZERO=0: they rise after 1 cycle.
- Latency: request accepted at edge N produces rsp_valid=1 during cycle N+1, with data and fault valid. rsp_valid is high for exactly that one cycle unless another request was accepted at edge N+1.
- The array read is registered. Offset, size and unsigned are registered alongside it. Lane select and extension are combinational from those registers.
- rst asserted mid-operation:
  - Immediately drops req_ready, rsp_valid and init_done.
  - Any in-flight response is lost and INIT restarts from word 0.
  - Array contents are undefined until the new sweep completes.
- req_valid during INIT is ignored; no response is generated.

## Structure
- Package dmem_pkg:
  - size encodings SIZE_B, SIZE_H, SIZE_W
  - state enum ST_INIT, ST_RUN
  - function for load lane extract and extend
- Sub-module dmem_ram: DEPTH x 32 single-port array with 4-bit byte write enable and registered read. No reset on the array.
- The top level holds the FSM, init pointer, decode/fault logic and response registers.

## Test plan
- Init: rst pulse, DEPTH=16, INIT_ZERO=1 -> req_ready rises exactly 16 cycles after release; LW 0x3C -> rsp_rdata 0x00000000, fault 0.
- Store/load word: SW 0x08 data 0xDEADBEEF, then LW 0x08 on the next cycle -> rsp_rdata 0xDEADBEEF, one cycle after the LW accept.
- Byte lanes: SW 0x10 = 0x11223344; SB 0x11 data 0xA5; LW 0x10 -> 0x1122A544. LB 0x11 -> 0xFFFFFFA5. LBU 0x11 -> 0x000000A5. LH 0x12 -> 0x00001122.
- Faults:
  - LH 0x01 -> fault=1, rdata 0.
  - SW 0x06 -> fault=1 and word 0x04 unchanged.
  - size 11 -> fault=1.
  - address 0x40 with DEPTH=16 -> fault=1.
- Back-to-back throughput: 8 consecutive accepted loads -> 8 consecutive rsp_valid cycles, in order.
- Reset mid-run: assert rst while rsp_valid is pending -> rsp_valid=0 immediately, no late pulse; req_ready stays low for DEPTH cycles after release.
